// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit; aligns and issues data-memory requests, stalls upstream while a request or load response is pending, extracts load data and registers the W-stage outputs. Ports: i_clk/i_arst; M-stage instruction fields (i_valid .. i_imm_ext); o_stall to freeze F/D/E; o_dmem_* request channel with i_dmem_req_ready; i_dmem_resp_valid/i_dmem_rdata response; o_misaligned; o_wb_valid .. o_imm_ext W-stage register.
module mem_stage_lsu #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic                    i_valid,
  input  logic                    i_mem_we,
  input  logic                    i_mem_re,
  input  logic [2:0]              i_func3,
  input  logic [DATA_WIDTH-1:0]   i_alu_result,
  input  logic [DATA_WIDTH-1:0]   i_write_data,
  input  logic [REG_ADDR_W-1:0]   i_rd_addr,
  input  logic                    i_reg_we,
  input  logic [2:0]              i_result_src,
  input  logic [ADDR_WIDTH-1:0]   i_pc_plus4,
  input  logic [DATA_WIDTH-1:0]   i_imm_ext,
  output logic                    o_stall,
  output logic                    o_dmem_req_valid,
  input  logic                    i_dmem_req_ready,
  output logic [ADDR_WIDTH-1:0]   o_dmem_addr,
  output logic                    o_dmem_we,
  output logic [DATA_WIDTH-1:0]   o_dmem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_dmem_wstrb,
  input  logic                    i_dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   i_dmem_rdata,
  output logic                    o_misaligned,
  output logic                    o_wb_valid,
  output logic                    o_reg_we,
  output logic [2:0]              o_result_src,
  output logic [DATA_WIDTH-1:0]   o_alu_result,
  output logic [DATA_WIDTH-1:0]   o_read_data,
  output logic [REG_ADDR_W-1:0]   o_rd_addr,
  output logic [ADDR_WIDTH-1:0]   o_pc_plus4,
  output logic [DATA_WIDTH-1:0]   o_imm_ext
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int OW = $clog2(SW);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic [OW-1:0] off;
  logic [1:0] size;
  logic mem_op, illegal, unaligned, bad, go, resp_ok;
  logic [DATA_WIDTH-1:0] sh, ld_data;
  assign off = i_alu_result[OW-1:0];
  assign size = i_func3[1:0];
  assign mem_op = i_mem_re | i_mem_we;
  // stores only have sizes 000..011; loads reject 111; doubleword needs a 64-bit datapath
  assign illegal = (size == 2'd3 && DATA_WIDTH == 32) | (i_mem_we ? i_func3[2] : i_func3 == 3'b111);
  assign unaligned = size == 2'd1 ? off[0] : size == 2'd2 ? |off[1:0] : size == 2'd3 ? |off : 1'b0;
  assign bad = i_valid & mem_op & (illegal | unaligned);
  assign go = i_valid & mem_op & ~bad;
  assign o_misaligned = bad & (state == IDLE) & ~i_arst;
  assign o_dmem_addr = ADDR_WIDTH'(i_alu_result) & ~ADDR_WIDTH'(SW - 1);
  assign o_dmem_we = i_mem_we;
  assign o_dmem_wdata = i_write_data << {off, 3'b000};
  assign o_dmem_wstrb = size == 2'd0 ? SW'(1) << off : size == 2'd1 ? SW'(3) << off : size == 2'd2 ? SW'(15) << off : '1;
  assign sh = i_dmem_rdata >> {off, 3'b000};
  // sized casts of signed operands sign-extend, of unsigned operands zero-extend
  assign ld_data = i_func3 == 3'b000 ? DATA_WIDTH'($signed(sh[7:0])) :
                   i_func3 == 3'b001 ? DATA_WIDTH'($signed(sh[15:0])) :
                   i_func3 == 3'b010 ? DATA_WIDTH'($signed(sh[31:0])) :
                   i_func3 == 3'b100 ? DATA_WIDTH'(sh[7:0]) :
                   i_func3 == 3'b101 ? DATA_WIDTH'(sh[15:0]) :
                   i_func3 == 3'b110 ? DATA_WIDTH'(sh[31:0]) : sh;
  always_ff @(posedge i_clk or posedge i_arst)
    if (i_arst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    o_dmem_req_valid = 1'b0;
    o_stall = 1'b0;
    resp_ok = 1'b0;
    case (state)
      IDLE, REQ: if (go | (state == REQ)) begin
        o_dmem_req_valid = 1'b1;
        o_stall = ~(i_dmem_req_ready & i_mem_we);
        state_nx = ~i_dmem_req_ready ? REQ : i_mem_we ? IDLE : RESP;
      end
      RESP: begin
        o_stall = ~i_dmem_resp_valid;
        resp_ok = i_dmem_resp_valid;
        state_nx = i_dmem_resp_valid ? IDLE : RESP;
      end
      default: state_nx = IDLE;
    endcase
    if (i_arst) begin
      o_dmem_req_valid = 1'b0;
      o_stall = 1'b0;
    end
  end
  // stalled cycles load a bubble; the data fields keep their last value
  always_ff @(posedge i_clk or posedge i_arst)
    if (i_arst) begin
      o_wb_valid <= 1'b0;
      o_reg_we <= 1'b0;
      o_result_src <= '0;
      o_alu_result <= '0;
      o_read_data <= '0;
      o_rd_addr <= '0;
      o_pc_plus4 <= '0;
      o_imm_ext <= '0;
    end else if (o_stall) begin
      o_wb_valid <= 1'b0;
      o_reg_we <= 1'b0;
    end else begin
      o_wb_valid <= i_valid;
      o_reg_we <= i_reg_we & i_valid & ~bad;
      o_result_src <= i_result_src;
      o_alu_result <= i_alu_result;
      o_read_data <= resp_ok ? ld_data : '0;
      o_rd_addr <= i_rd_addr;
      o_pc_plus4 <= i_pc_plus4;
      o_imm_ext <= i_imm_ext;
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed bench for mem_stage_lsu with a transaction-level model and a per-cycle compare process.
module tb_mem_stage_lsu;
  logic i_clk = 1'b0, i_arst = 1'b1;
  logic i_valid = 0, i_mem_we = 0, i_mem_re = 0, i_reg_we = 0;
  logic [2:0] i_func3 = 0, i_result_src = 0;
  logic [63:0] i_alu_result = 0, i_write_data = 0, i_pc_plus4 = 0, i_imm_ext = 0, i_dmem_rdata = 0;
  logic [4:0] i_rd_addr = 0;
  logic i_dmem_req_ready = 0, i_dmem_resp_valid = 0;
  logic o_stall, o_dmem_req_valid, o_dmem_we, o_misaligned, o_wb_valid, o_reg_we;
  logic [63:0] o_dmem_addr, o_dmem_wdata, o_alu_result, o_read_data, o_pc_plus4, o_imm_ext;
  logic [7:0] o_dmem_wstrb;
  logic [2:0] o_result_src;
  logic [4:0] o_rd_addr;
  always #5 i_clk = ~i_clk;
  mem_stage_lsu dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_valid(i_valid), .i_mem_we(i_mem_we), .i_mem_re(i_mem_re),
    .i_func3(i_func3), .i_alu_result(i_alu_result), .i_write_data(i_write_data), .i_rd_addr(i_rd_addr),
    .i_reg_we(i_reg_we), .i_result_src(i_result_src), .i_pc_plus4(i_pc_plus4), .i_imm_ext(i_imm_ext),
    .o_stall(o_stall), .o_dmem_req_valid(o_dmem_req_valid), .i_dmem_req_ready(i_dmem_req_ready),
    .o_dmem_addr(o_dmem_addr), .o_dmem_we(o_dmem_we), .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_resp_valid(i_dmem_resp_valid), .i_dmem_rdata(i_dmem_rdata), .o_misaligned(o_misaligned),
    .o_wb_valid(o_wb_valid), .o_reg_we(o_reg_we), .o_result_src(o_result_src), .o_alu_result(o_alu_result),
    .o_read_data(o_read_data), .o_rd_addr(o_rd_addr), .o_pc_plus4(o_pc_plus4), .o_imm_ext(o_imm_ext)
  );
  int checks = 0, errors = 0, seq = 0;
  int n_stall = 0, n_req = 0, n_wb = 0;
  logic [63:0] seen_wdata = 0;
  logic [7:0] seen_wstrb = 0;
  logic e_stall = 0, e_req = 0, e_mis = 0, e_we = 0;
  logic [63:0] e_addr = 0, e_wdata = 0;
  logic [7:0] e_wstrb = 0;
  typedef struct packed {
    logic valid, reg_we, load;
    logic [4:0] rd;
    logic [2:0] src;
    logic [63:0] alu, pc4, imm, rdat;
  } wb_t;
  wb_t m_rec = '0, x = '0;
  logic m_done = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", n, $time, a, e);
    end
  endtask
  // expected W-stage contents: the finished instruction, otherwise a bubble
  always @(posedge i_clk or posedge i_arst) x <= i_arst ? '0 : m_done ? m_rec : '0;
  always @(negedge i_clk) if (!i_arst) begin
    chk("stall", 64'(o_stall), 64'(e_stall));
    chk("req_valid", 64'(o_dmem_req_valid), 64'(e_req));
    chk("misaligned", 64'(o_misaligned), 64'(e_mis));
    if (e_req) begin
      chk("dmem_addr", o_dmem_addr, e_addr);
      chk("dmem_we", 64'(o_dmem_we), 64'(e_we));
      chk("dmem_wstrb", 64'(o_dmem_wstrb), 64'(e_wstrb));
      chk("dmem_wdata", o_dmem_wdata, e_wdata);
    end
    chk("wb_valid", 64'(o_wb_valid), 64'(x.valid));
    chk("reg_we", 64'(o_reg_we), 64'(x.reg_we));
    if (x.valid) begin
      chk("rd_addr", 64'(o_rd_addr), 64'(x.rd));
      chk("result_src", 64'(o_result_src), 64'(x.src));
      chk("alu_result", o_alu_result, x.alu);
      chk("pc_plus4", o_pc_plus4, x.pc4);
      chk("imm_ext", o_imm_ext, x.imm);
    end
    if (x.load) chk("read_data", o_read_data, x.rdat);
    if (o_stall) n_stall++;
    if (o_wb_valid) n_wb++;
    if (o_dmem_req_valid) begin
      n_req++;
      seen_wstrb = o_dmem_wstrb;
      seen_wdata = o_dmem_wdata;
    end
  end
  task automatic idle(input int n);
    i_valid = 0;
    i_mem_re = 0;
    i_mem_we = 0;
    e_stall = 0;
    e_req = 0;
    e_mis = 0;
    m_done = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask
  // kind: 0 non-memory, 1 load, 2 store; rdly = cycles ready stays low; pdly = RESP cycles before data
  task automatic run_op(input int kind, input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] wd,
                        input logic [63:0] rdata, input int rdly, input int pdly, input bit spur, input bit v, input bit rwe);
    int nb, off, stall_n, total;
    bit ill, bad, go;
    logic [63:0] lm, ld;
    seq++;
    nb = 1 << f3[1:0];
    off = int'(alu[2:0]);
    ill = (kind == 2) ? f3[2] : (f3 == 3'b111);
    bad = v && kind != 0 && (ill || (off % nb) != 0);
    go = v && kind != 0 && !bad;
    stall_n = !go ? 0 : (kind == 2) ? rdly : rdly + 1 + pdly;
    total = !go ? 1 : (kind == 2) ? rdly + 1 : rdly + 2 + pdly;
    lm = (nb == 8) ? '1 : (64'd1 << (8 * nb)) - 64'd1;
    ld = (rdata >> (8 * off)) & lm;
    if (!f3[2] && ld[8*nb-1]) ld = ld | ~lm;
    i_valid = v;
    i_mem_re = kind == 1;
    i_mem_we = kind == 2;
    i_func3 = f3;
    i_alu_result = alu;
    i_write_data = wd;
    i_dmem_rdata = rdata;
    i_rd_addr = 5'(seq);
    i_reg_we = rwe;
    i_result_src = 3'(seq % 5);
    i_pc_plus4 = 64'h1000 + 64'(4 * seq);
    i_imm_ext = 64'(seq) * 64'h11;
    e_mis = bad;
    e_we = kind == 2;
    e_addr = alu & ~64'h7;
    e_wstrb = 8'(((1 << nb) - 1) << off);
    e_wdata = wd << (8 * off);
    m_rec = '{valid: v, reg_we: v && rwe && !bad, load: go && kind == 1, rd: 5'(seq), src: 3'(seq % 5),
              alu: alu, pc4: 64'h1000 + 64'(4 * seq), imm: 64'(seq) * 64'h11, rdat: ld};
    for (int k = 0; k < total; k++) begin
      e_req = go && k <= rdly;
      e_stall = k < stall_n;
      i_dmem_req_ready = !go || k == rdly;
      i_dmem_resp_valid = (go && kind == 1 && k == total - 1) || (spur && k <= rdly);
      m_done = k == total - 1;
      @(posedge i_clk);
      #1;
    end
    m_done = 0;
    i_dmem_req_ready = 0;
    i_dmem_resp_valid = 0;
  endtask
  initial begin
    int s, r, w;
    #3;
    chk("rst_stall", 64'(o_stall), 64'd0);
    chk("rst_req", 64'(o_dmem_req_valid), 64'd0);
    chk("rst_wb_valid", 64'(o_wb_valid), 64'd0);
    chk("rst_read_data", o_read_data, 64'd0);
    @(posedge i_clk);
    #1;
    i_arst = 0;
    idle(2);
    run_op(0, 3'b000, 64'h1234, 0, 0, 0, 0, 0, 1, 1);
    s = n_stall;
    run_op(1, 3'b010, 64'h104, 0, 64'hFFFF_FFFE_0000_0000, 0, 2, 0, 1, 1);
    chk("lw_data", o_read_data, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("lw_stall_cycles", 64'(n_stall - s), 64'd3);
    s = n_stall;
    r = n_req;
    run_op(2, 3'b001, 64'h0A, 64'hBEEF, 0, 2, 0, 0, 1, 0);
    chk("sh_wstrb", 64'(seen_wstrb), 64'h0C);
    chk("sh_wdata", seen_wdata, 64'h0000_0000_BEEF_0000);
    chk("sh_req_cycles", 64'(n_req - r), 64'd3);
    chk("sh_stall_cycles", 64'(n_stall - s), 64'd2);
    r = n_req;
    run_op(1, 3'b010, 64'h102, 0, 0, 0, 0, 0, 1, 1);
    chk("mis_wb_valid", 64'(o_wb_valid), 64'd1);
    chk("mis_reg_we", 64'(o_reg_we), 64'd0);
    chk("mis_no_req", 64'(n_req - r), 64'd0);
    run_op(1, 3'b100, 64'h7, 0, 64'hFF00_0000_0000_0000, 1, 0, 0, 1, 1);
    chk("lbu_data", o_read_data, 64'hFF);
    run_op(1, 3'b000, 64'h7, 0, 64'hFF00_0000_0000_0000, 0, 1, 0, 1, 1);
    chk("lb_data", o_read_data, 64'hFFFF_FFFF_FFFF_FFFF);
    s = n_stall;
    run_op(2, 3'b000, 64'h13, 64'hAA, 0, 0, 0, 0, 1, 0);
    chk("sb_no_stall", 64'(n_stall - s), 64'd0);
    run_op(2, 3'b010, 64'h24, 64'h1122_3344, 0, 1, 0, 1, 1, 0);
    run_op(2, 3'b011, 64'h40, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 1, 0);
    run_op(1, 3'b011, 64'h48, 0, 64'h8765_4321_0FED_CBA9, 1, 0, 1, 1, 1);
    run_op(1, 3'b101, 64'h66, 0, 64'h1234_8001_5678_9ABC, 0, 0, 0, 1, 1);
    run_op(1, 3'b001, 64'h62, 0, 64'h0000_0000_8001_0000, 0, 0, 0, 1, 1);
    chk("lh_data", o_read_data, 64'hFFFF_FFFF_FFFF_8001);
    run_op(1, 3'b110, 64'h10C, 0, 64'hDEAD_BEEF_0000_0000, 2, 1, 0, 1, 1);
    chk("lwu_data", o_read_data, 64'h0000_0000_DEAD_BEEF);
    run_op(1, 3'b010, 64'h10C, 0, 64'hDEAD_BEEF_0000_0000, 0, 0, 0, 1, 1);
    run_op(2, 3'b011, 64'h44, 64'h55, 0, 0, 0, 0, 1, 0);
    run_op(2, 3'b100, 64'h20, 64'h55, 0, 0, 0, 0, 1, 0);
    run_op(1, 3'b111, 64'h20, 0, 0, 0, 0, 0, 1, 1);
    run_op(2, 3'b001, 64'h01, 64'h77, 0, 0, 0, 0, 1, 0);
    run_op(1, 3'b010, 64'h30, 0, 64'h1, 0, 0, 0, 0, 1);
    idle(1);
    w = n_wb;
    run_op(0, 3'b000, 64'h11, 0, 0, 0, 0, 0, 1, 1);
    run_op(1, 3'b011, 64'h80, 0, 64'h0102_0304_0506_0708, 1, 1, 0, 1, 1);
    run_op(0, 3'b000, 64'h22, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    chk("b2b_wb_count", 64'(n_wb - w), 64'd3);
    i_valid = 1;
    i_mem_re = 1;
    i_mem_we = 0;
    i_func3 = 3'b011;
    i_alu_result = 64'h200;
    i_write_data = 0;
    i_reg_we = 1;
    i_dmem_req_ready = 1;
    e_req = 1;
    e_stall = 1;
    e_mis = 0;
    e_we = 0;
    e_addr = 64'h200;
    e_wstrb = 8'hFF;
    e_wdata = 0;
    @(posedge i_clk);
    #1;
    i_dmem_req_ready = 0;
    e_req = 0;
    @(negedge i_clk);
    #2;
    i_arst = 1;
    #1;
    chk("arst_stall", 64'(o_stall), 64'd0);
    chk("arst_req", 64'(o_dmem_req_valid), 64'd0);
    chk("arst_wb_valid", 64'(o_wb_valid), 64'd0);
    chk("arst_alu", o_alu_result, 64'd0);
    chk("arst_pc4", o_pc_plus4, 64'd0);
    i_valid = 0;
    i_mem_re = 0;
    i_reg_we = 0;
    i_func3 = 0;
    i_alu_result = 0;
    i_rd_addr = 0;
    i_result_src = 0;
    i_pc_plus4 = 0;
    i_imm_ext = 0;
    i_dmem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    e_stall = 0;
    @(posedge i_clk);
    #1;
    i_arst = 0;
    i_dmem_resp_valid = 1;
    @(posedge i_clk);
    #1;
    i_dmem_resp_valid = 0;
    chk("late_resp_stall", 64'(o_stall), 64'd0);
    chk("late_resp_wb_valid", 64'(o_wb_valid), 64'd0);
    chk("late_resp_reg_we", 64'(o_reg_we), 64'd0);
    chk("late_resp_read_data", o_read_data, 64'd0);
    chk("late_resp_imm", o_imm_ext, 64'd0);
    s = n_stall;
    run_op(1, 3'b010, 64'h30, 0, 64'h0000_0000_7654_3210, 0, 0, 0, 1, 1);
    chk("post_rst_lw", o_read_data, 64'h7654_3210);
    chk("post_rst_stall", 64'(n_stall - s), 64'd1);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
